// File: rtl/axi_stream_packet_arbiter_if.sv
// Bundled AXI4-Stream lanes: with LANES>1, lane i's fields sit side by side at [i*W +: W].
// The master modport drives payload/valid; the slave modport drives tready.
interface axi_stream_packet_arbiter_if #(
    parameter int LANES      = 1,
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tready;
    logic [LANES*8*BYTE_WIDTH-1:0] tdata;
    logic [LANES*BYTE_WIDTH-1:0]   tstrb;
    logic [LANES*BYTE_WIDTH-1:0]   tkeep;
    logic [LANES-1:0]              tlast;
    logic [LANES*ID_WIDTH-1:0]     tid;
    logic [LANES*DEST_WIDTH-1:0]   tdest;
    logic [LANES*USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi_stream_packet_arbiter.sv
// N:1 packet-granular round-robin AXI4-Stream arbiter; 1-cycle arbitration, then 1 beat/cycle,
// inputs backpressured by m.tready on the locked port only. AXIS_ARB_SRCID_EN prepends grant_idx to m.tid.
module axi_stream_packet_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    axi_stream_packet_arbiter_if.slave    s,
    axi_stream_packet_arbiter_if.master   m,
    output logic                          grant_active,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_idx
);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int DW    = 8 * BYTE_WIDTH;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     rr_ptr;
    logic [SEL_W-1:0]     pick;
    logic [SEL_W-1:0]     cand;
    logic                 pick_vld;
    logic                 beat_xfer;
    logic [NUM_PORTS-1:0] rdy;

    // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = rr_ptr;
        cand     = rr_ptr;
        pick_vld = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = SEL_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (s.tvalid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign m.tvalid = grant_active & s.tvalid[grant_idx];
    assign m.tdata  = s.tdata[int'(grant_idx)*DW +: DW];
    assign m.tstrb  = s.tstrb[int'(grant_idx)*BYTE_WIDTH +: BYTE_WIDTH];
    assign m.tkeep  = s.tkeep[int'(grant_idx)*BYTE_WIDTH +: BYTE_WIDTH];
    assign m.tlast  = s.tlast[grant_idx];
    assign m.tdest  = s.tdest[int'(grant_idx)*DEST_WIDTH +: DEST_WIDTH];
    assign m.tuser  = s.tuser[int'(grant_idx)*USER_WIDTH +: USER_WIDTH];

`ifdef AXIS_ARB_SRCID_EN
    assign m.tid = {grant_idx, s.tid[int'(grant_idx)*ID_WIDTH +: ID_WIDTH]};
`else
    assign m.tid = s.tid[int'(grant_idx)*ID_WIDTH +: ID_WIDTH];
`endif

    // tready depends only on registered grant state and m.tready, never on s.tvalid.
    always_comb begin
        rdy = '0;
        if (grant_active) begin
            rdy[grant_idx] = m.tready[0];
        end
    end
    assign s.tready = rdy;

    assign beat_xfer = m.tvalid[0] & m.tready[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            grant_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_idx    <= pick;
                        grant_active <= 1'b1;
                        state        <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (beat_xfer && s.tlast[grant_idx]) begin
                        state        <= IDLE;
                        grant_active <= 1'b0;
                        rr_ptr       <= (grant_idx == SEL_W'(NUM_PORTS - 1)) ? '0
                                                                            : grant_idx + SEL_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed bench for axi_stream_packet_arbiter: reset, round-robin, backpressure, single request,
// wrap with mid-packet valid gap, and tid export (AXIS_ARB_SRCID_EN aware).
module tb_axi_stream_packet_arbiter;
    localparam int NP    = 4;
    localparam int BW    = 4;
    localparam int IDW   = 1;
    localparam int SEL_W = 2;
`ifdef AXIS_ARB_SRCID_EN
    localparam int MIDW = IDW + SEL_W;
`else
    localparam int MIDW = IDW;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic             grant_active;
    logic [SEL_W-1:0] grant_idx;
    int               vectors = 0;
    int               errors  = 0;
    int               order [6] = '{0, 1, 3, 0, 1, 3};
    int               bcnt  [4];

    always #5 clk = ~clk;

    axi_stream_packet_arbiter_if #(.LANES(NP), .BYTE_WIDTH(BW), .ID_WIDTH(IDW),
                                   .DEST_WIDTH(1), .USER_WIDTH(1)) s_bus ();
    axi_stream_packet_arbiter_if #(.LANES(1), .BYTE_WIDTH(BW), .ID_WIDTH(MIDW),
                                   .DEST_WIDTH(1), .USER_WIDTH(1)) m_bus ();

    axi_stream_packet_arbiter #(
        .NUM_PORTS(NP), .BYTE_WIDTH(BW), .ID_WIDTH(IDW), .DEST_WIDTH(1), .USER_WIDTH(1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s            (s_bus),
        .m            (m_bus),
        .grant_active (grant_active),
        .grant_idx    (grant_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit v, input logic [31:0] d, input bit l,
                         input logic [0:0] id);
        s_bus.tvalid[p]       = v;
        s_bus.tdata[p*32 +: 32] = d;
        s_bus.tlast[p]        = l;
        s_bus.tid[p]          = id[0];
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, " grant_active"}, 64'(grant_active), 64'd0);
        chk({tag, " m_tvalid"},     64'(m_bus.tvalid), 64'd0);
        chk({tag, " s_tready"},     64'(s_bus.tready), 64'd0);
    endtask

    task automatic exp_locked(input string tag, input int g, input logic [31:0] d,
                              input bit l, input logic [0:0] id);
        logic [1:0]      gi;
        logic [MIDW-1:0] etid;
        gi = 2'(g);
`ifdef AXIS_ARB_SRCID_EN
        etid = {gi, id};
`else
        etid = id;
`endif
        chk({tag, " grant_active"}, 64'(grant_active), 64'd1);
        chk({tag, " grant_idx"},    64'(grant_idx),    64'(gi));
        chk({tag, " m_tvalid"},     64'(m_bus.tvalid), 64'd1);
        chk({tag, " m_tdata"},      64'(m_bus.tdata),  64'(d));
        chk({tag, " m_tlast"},      64'(m_bus.tlast),  64'(l));
        chk({tag, " m_tid"},        64'(m_bus.tid),    64'(etid));
        chk({tag, " s_tready"},     64'(s_bus.tready), 64'(4'b0001 << g));
    endtask

    initial begin
        // T1: reset with every input requesting
        resetn       = 1'b0;
        s_bus.tvalid = 4'hF;
        s_bus.tdata  = '0;
        s_bus.tstrb  = {4'h8, 4'h4, 4'h2, 4'h1};
        s_bus.tkeep  = 16'hFFFF;
        s_bus.tlast  = '0;
        s_bus.tid    = '0;
        s_bus.tdest  = 4'b1010;
        s_bus.tuser  = 4'b1100;
        m_bus.tready = 1'b1;
        #12;
        exp_idle("t1 reset");
        chk("t1 grant_idx", 64'(grant_idx), 64'd0);
        s_bus.tvalid = '0;
        @(negedge clk);
        resetn = 1'b1;

        // T3: ports 0,1,3 each with two 2-beat packets, rr_ptr starts at 0
        tick();
        for (int p = 0; p < NP; p++) bcnt[p] = 0;
        drive(0, 1'b1, 32'h00, 1'b0, 1'b0);
        drive(1, 1'b1, 32'h10, 1'b0, 1'b0);
        drive(3, 1'b1, 32'h30, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            int p;
            p = order[i];
            #1;
            exp_idle($sformatf("t3 pkt%0d idle", i));
            tick();
            exp_locked($sformatf("t3 pkt%0d b0", i), p, 32'(p*16 + bcnt[p]), 1'b0, 1'b0);
            tick();
            bcnt[p]++;
            drive(p, 1'b1, 32'(p*16 + bcnt[p]), 1'b1, 1'b0);
            #1;
            exp_locked($sformatf("t3 pkt%0d b1", i), p, 32'(p*16 + bcnt[p]), 1'b1, 1'b0);
            tick();
            bcnt[p]++;
            if (bcnt[p] < 4) drive(p, 1'b1, 32'(p*16 + bcnt[p]), 1'b0, 1'b0);
            else             drive(p, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        // T4: port1 locked, 5 cycles of backpressure mid-packet
        drive(1, 1'b1, 32'hB0, 1'b0, 1'b0);
        #1;
        exp_idle("t4 idle");
        tick();
        exp_locked("t4 b0", 1, 32'hB0, 1'b0, 1'b0);
        chk("t4 m_tdest", 64'(m_bus.tdest), 64'd1);
        chk("t4 m_tuser", 64'(m_bus.tuser), 64'd0);
        tick();
        drive(1, 1'b1, 32'hB1, 1'b0, 1'b0);
        m_bus.tready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4 stall%0d m_tvalid", c), 64'(m_bus.tvalid), 64'd1);
            chk($sformatf("t4 stall%0d m_tdata", c),  64'(m_bus.tdata),  64'hB1);
            chk($sformatf("t4 stall%0d m_tlast", c),  64'(m_bus.tlast),  64'd0);
            chk($sformatf("t4 stall%0d s_tready", c), 64'(s_bus.tready), 64'd0);
            chk($sformatf("t4 stall%0d grant_idx", c), 64'(grant_idx),   64'd1);
            tick();
        end
        m_bus.tready = 1'b1;
        #1;
        exp_locked("t4 resume b1", 1, 32'hB1, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'hB2, 1'b0, 1'b0);
        #1;
        exp_locked("t4 b2", 1, 32'hB2, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 32'hB3, 1'b1, 1'b0);
        #1;
        exp_locked("t4 b3", 1, 32'hB3, 1'b1, 1'b0);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0);

        // T2: port2 alone, 3-beat packet, rr_ptr now 2
        drive(2, 1'b1, 32'hA0, 1'b0, 1'b0);
        #1;
        exp_idle("t2 idle");
        tick();
        exp_locked("t2 b0", 2, 32'hA0, 1'b0, 1'b0);
        chk("t2 m_tstrb", 64'(m_bus.tstrb), 64'h4);
        chk("t2 m_tkeep", 64'(m_bus.tkeep), 64'hF);
        chk("t2 m_tdest", 64'(m_bus.tdest), 64'd0);
        chk("t2 m_tuser", 64'(m_bus.tuser), 64'd1);
        tick();
        drive(2, 1'b1, 32'hA1, 1'b0, 1'b0);
        #1;
        exp_locked("t2 b1", 2, 32'hA1, 1'b0, 1'b0);
        tick();
        drive(2, 1'b1, 32'hA2, 1'b1, 1'b0);
        #1;
        exp_locked("t2 b2", 2, 32'hA2, 1'b1, 1'b0);
        tick();
        drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        exp_idle("t2 done");

        // T5: rr_ptr=3, only port0 requests; 2-cycle valid gap mid-packet
        drive(0, 1'b1, 32'hC0, 1'b0, 1'b0);
        #1;
        exp_idle("t5 idle");
        tick();
        exp_locked("t5 b0", 0, 32'hC0, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 32'hC1, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("t5 gap%0d grant_active", c), 64'(grant_active), 64'd1);
            chk($sformatf("t5 gap%0d grant_idx", c),    64'(grant_idx),    64'd0);
            chk($sformatf("t5 gap%0d m_tvalid", c),     64'(m_bus.tvalid), 64'd0);
            chk($sformatf("t5 gap%0d s_tready", c),     64'(s_bus.tready), 64'd1);
            tick();
        end
        drive(0, 1'b1, 32'hC1, 1'b0, 1'b0);
        #1;
        exp_locked("t5 b1", 0, 32'hC1, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, 32'hC2, 1'b1, 1'b0);
        #1;
        exp_locked("t5 b2", 0, 32'hC2, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0);

        // T6: single-beat packet on port3 carrying tid=1
        drive(3, 1'b1, 32'hD0, 1'b1, 1'b1);
        #1;
        exp_idle("t6 idle");
        tick();
        exp_locked("t6 b0", 3, 32'hD0, 1'b1, 1'b1);
        tick();
        drive(3, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        exp_idle("t6 done");
        tick();
        exp_idle("t6 stays idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
